video_sync_detector: RTL
========================

VIDEO_SYNC_DETECTOR -- requirements
Module: video_sync_detector

Interface
REQ-001 Parameter EXP_HORI_LINE, default 800, expected clocks per line (HS falling edge to HS falling edge).
REQ-002 Parameter EXP_VERT_LINE, default 525, expected lines per frame (VS falling edge to VS falling edge).
REQ-003 Parameter LOCK_FRAMES, default 2, consecutive matching frames required for lock; range 1..7.
REQ-004 vga_clk  input  1  pixel clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 HS  input  1  horizontal sync, active low.
REQ-007 VS  input  1  vertical sync, active low.
REQ-008 blank_n  input  1  high during visible pixels.
REQ-009 pixel_x  output  11  index of current visible pixel within line.
REQ-010 pixel_y  output  10  index of current visible line within frame.
REQ-011 pixel_valid  output  1  pixel_x/pixel_y address a visible pixel.
REQ-012 line_start  output  1  one-cycle pulse on each HS falling edge.
REQ-013 frame_start  output  1  one-cycle pulse on each VS falling edge.
REQ-014 locked  output  1  timing matches expected values.
REQ-015 h_total  output  11  last measured line length in clocks.
REQ-016 v_total  output  10  last measured frame length in lines.
REQ-017 timing_err  output  1  one-cycle pulse on mismatch while locked or on watchdog.
REQ-018 err_count  output  16  accumulated error count (see Configuration).

Function
REQ-019 HS, VS, blank_n SHALL be registered once; edge detection SHALL compare registered value with its previous registered value.
REQ-020 Every output SHALL be registered; pixel_valid, line_start, frame_start SHALL lag the corresponding input change by exactly 2 clocks.
REQ-021 h_cnt (11 bit) SHALL clear on HS falling edge and otherwise increment, saturating at 2047; h_total SHALL load h_cnt+1 on each HS falling edge.
REQ-022 v_cnt (10 bit) SHALL clear on VS falling edge and increment on each HS falling edge; v_total SHALL load v_cnt on each VS falling edge.
REQ-023 pixel_x SHALL clear on HS falling edge and increment each clock blank_n is high; pixel_y SHALL clear on VS falling edge and increment on each blank_n falling edge.
REQ-024 pixel_valid SHALL equal registered blank_n AND locked.
REQ-025 FSM states SEARCH, MEASURE, LOCKED; SEARCH -> MEASURE on VS falling edge, clearing match counter.
REQ-026 MEASURE: any h_total load /= EXP_HORI_LINE SHALL mark frame bad; on VS falling edge, good frame with v_total == EXP_VERT_LINE increments match counter, else match counter clears; match counter reaching LOCK_FRAMES -> LOCKED.
REQ-027 LOCKED: line or frame length mismatch SHALL pulse timing_err, deassert locked next clock, go to SEARCH.
REQ-028 h_cnt saturation (no HS for 2048 clocks) in any state SHALL pulse timing_err once and go to SEARCH.
REQ-029 HS and VS falling on the same clock SHALL evaluate line check first, then frame check, in that cycle.

Reset
REQ-030 reset_n low SHALL force state SEARCH, all counters 0, all outputs 0, registered HS/VS to 1, registered blank_n to 0.
REQ-031 Reset mid-frame SHALL discard partial measurements; relock requires LOCK_FRAMES full frames after the first VS falling edge post-reset.

Configuration
REQ-032 With VIDEO_SYNC_DETECTOR_ERR_COUNT_EN defined, err_count SHALL increment on each timing_err pulse, saturate at 65535, clear only on reset.
REQ-033 Without VIDEO_SYNC_DETECTOR_ERR_COUNT_EN, err_count SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-034 Standard 800x525 stream (HS low 96, VS low 2 lines, visible h 144..783, v 34..513) -> locked rises after the 3rd VS falling edge; h_total=800, v_total=525.
REQ-035 Locked stream -> pixel_x sweeps 0..639 and pixel_y 0..479 with pixel_valid; 307200 valid cycles per frame.
REQ-036 Locked, one line shortened to 799 clocks -> timing_err single pulse, locked low, err_count=1, relock after 2 good frames.
REQ-037 HS held high 2048 clocks -> single timing_err pulse, state SEARCH, no repeat until next HS edge resumes counting.
REQ-038 reset_n low mid-frame for 3 clocks -> all outputs 0 during and after; locked rises again only after 3rd post-reset VS falling edge.
REQ-039 Macro undefined, 5 injected errors -> err_count stays 0; macro defined -> err_count=5.

Source files
------------

// File: rtl/video_sync_detector.sv
// Video sync timing detector: measures HS/VS periods, locks on the expected raster, and emits pixel coordinates.
// Define VIDEO_SYNC_DETECTOR_ERR_COUNT_EN to build the saturating timing-error counter on err_count.
module video_sync_detector #(
  parameter int EXP_HORI_LINE = 800,
  parameter int EXP_VERT_LINE = 525,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        HS,
  input  logic        VS,
  input  logic        blank_n,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [9:0]  v_total,
  output logic        timing_err,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state;
  logic        hs_r, vs_r, blank_r;
  logic        hs_d, vs_d, blank_d;
  logic        hs_fall, vs_fall, blank_fall;
  logic [10:0] h_cnt, x_cnt;
  logic [9:0]  v_cnt, y_cnt;
  logic [10:0] h_meas;
  logic [9:0]  v_meas;
  logic        line_bad, frame_mismatch, frame_ok, wd_fire, err_fire;
  logic [2:0]  match_cnt;
  logic        frame_bad;

  always_comb begin
    hs_fall        = hs_d & ~hs_r;
    vs_fall        = vs_d & ~vs_r;
    blank_fall     = blank_d & ~blank_r;
    h_meas         = (h_cnt == '1) ? h_cnt : h_cnt + 11'd1;
    // A line whose HS edge lands on the VS edge is counted into the frame it closes.
    v_meas         = (hs_fall && v_cnt != '1) ? v_cnt + 10'd1 : v_cnt;
    line_bad       = hs_fall && (h_meas != 11'(EXP_HORI_LINE));
    frame_mismatch = vs_fall && (v_meas != 10'(EXP_VERT_LINE));
    frame_ok       = !frame_bad && !line_bad && (v_meas == 10'(EXP_VERT_LINE));
    wd_fire        = !hs_fall && (h_cnt == 11'd2046);
    err_fire       = wd_fire || ((state == LOCKED) && (line_bad || frame_mismatch));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      blank_r <= 1'b0;
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
      blank_d <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      x_cnt   <= '0;
      y_cnt   <= '0;
    end else begin
      hs_r    <= HS;
      vs_r    <= VS;
      blank_r <= blank_n;
      hs_d    <= hs_r;
      vs_d    <= vs_r;
      blank_d <= blank_r;
      if (hs_fall)              h_cnt <= '0;
      else if (h_cnt != '1)     h_cnt <= h_cnt + 11'd1;
      if (vs_fall)              v_cnt <= '0;
      else if (hs_fall && v_cnt != '1) v_cnt <= v_cnt + 10'd1;
      if (hs_fall)              x_cnt <= '0;
      else if (blank_r && x_cnt != '1) x_cnt <= x_cnt + 11'd1;
      if (vs_fall)              y_cnt <= '0;
      else if (blank_fall && y_cnt != '1) y_cnt <= y_cnt + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
    end else begin
      pixel_x     <= x_cnt;
      pixel_y     <= y_cnt;
      pixel_valid <= blank_r & locked;
      line_start  <= hs_fall;
      frame_start <= vs_fall;
      if (hs_fall) h_total <= h_meas;
      if (vs_fall) v_total <= v_meas;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      match_cnt  <= '0;
      frame_bad  <= 1'b0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= err_fire;
      if (err_fire) begin
        state  <= SEARCH;
        locked <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (vs_fall) begin
              state     <= MEASURE;
              match_cnt <= '0;
              frame_bad <= 1'b0;
            end
          end
          MEASURE: begin
            if (vs_fall) begin
              frame_bad <= 1'b0;
              if (frame_ok) begin
                match_cnt <= match_cnt + 3'd1;
                if (match_cnt + 3'd1 == 3'(LOCK_FRAMES)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
              end
            end else if (line_bad) begin
              frame_bad <= 1'b1;
            end
          end
          LOCKED: ;
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VIDEO_SYNC_DETECTOR_ERR_COUNT_EN
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)                        err_count <= '0;
    else if (err_fire && err_count != '1) err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule
